multicycle_core: RTL



---
 rtl/multicycle_core.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Multicycle CPU core: FETCH/EXEC/MEM/HALTED sequencing, latched Z/N flags and a req/ack data port.
// Optional macro STACK_GUARD_EN: PUSH at sp==0 or POP at the reset sp faults and halts instead of accessing memory.
module multicycle_core #(
   parameter int DW   = 16,
   parameter int AW   = 10,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] imem_addr,
   input  logic [15:0]   imem_rdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic [DW-1:0] dmem_rdata,
   input  logic          dmem_ack,
   output logic          halted,
   output logic          fault
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [AW-1:0] SP_RST = {{(AW-1){1'b1}}, 1'b0};
   localparam logic [AW-1:0] ONE_A  = AW'(1);

   state_t        r_state, w_state_nxt;
   logic [DW-1:0] r_regs [NREG];
   logic [AW-1:0] r_pc, r_sp, r_dmem_addr;
   logic [DW-1:0] r_dmem_wdata;
   logic          r_z, r_n, r_dmem_req, r_dmem_we, r_halted, r_fault;
   logic [3:0]    r_op, r_rd;

   logic [3:0]    w_op, w_rd, w_rx, w_ry;
   logic [DW-1:0] w_rx_val, w_ry_val, w_rd_val, w_imm, w_res;
   logic [AW-1:0] w_tgt;
   logic          w_alu_wr, w_flag_wr, w_taken, w_guard;

   logic [AW-1:0] w_pc_nxt, w_sp_nxt, w_addr_nxt;
   logic [DW-1:0] w_wdata_nxt, w_rf_data;
   logic [3:0]    w_rf_idx;
   logic          w_z_nxt, w_n_nxt, w_req_nxt, w_we_nxt, w_halt_nxt, w_fault_nxt, w_rf_we;

   assign w_op  = imem_rdata[15:12];
   assign w_rd  = imem_rdata[11:8];
   assign w_rx  = imem_rdata[7:4];
   assign w_ry  = imem_rdata[3:0];
   assign w_imm = {{(DW-8){imem_rdata[7]}}, imem_rdata[7:0]};
   assign w_tgt = AW'(imem_rdata[9:0]);

   // Indices beyond the implemented file read as zero
   assign w_rx_val = (int'(w_rx) < NREG) ? r_regs[w_rx] : '0;
   assign w_ry_val = (int'(w_ry) < NREG) ? r_regs[w_ry] : '0;
   assign w_rd_val = (int'(w_rd) < NREG) ? r_regs[w_rd] : '0;

   always_comb begin
      w_res     = '0;
      w_alu_wr  = 1'b0;
      w_flag_wr = 1'b0;
      case (w_op)
         4'h1: begin w_res = w_rx_val + w_ry_val;     w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h2: begin w_res = w_rx_val - w_ry_val;     w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h3: begin w_res = w_rx_val & w_ry_val;     w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h4: begin w_res = w_rx_val | w_ry_val;     w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h5: begin w_res = w_rd_val + w_imm;        w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h6: begin w_res = w_imm;                   w_alu_wr = 1'b1; end
         4'h7: begin w_res = w_rx_val << imem_rdata[3:0]; w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'h8: begin w_res = w_rx_val >> imem_rdata[3:0]; w_alu_wr = 1'b1; w_flag_wr = 1'b1; end
         4'hE: begin w_res = w_rx_val - w_ry_val;     w_flag_wr = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      case (imem_rdata[11:10])
         2'b00:   w_taken = 1'b1;
         2'b01:   w_taken = r_z;
         2'b10:   w_taken = r_n;
         default: w_taken = r_z | r_n;
      endcase
   end

`ifdef STACK_GUARD_EN
   assign w_guard = ((w_op == 4'hB) && (r_sp == '0)) || ((w_op == 4'hC) && (r_sp == SP_RST));
`else
   assign w_guard = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_sp_nxt    = r_sp;
      w_z_nxt     = r_z;
      w_n_nxt     = r_n;
      w_req_nxt   = r_dmem_req;
      w_we_nxt    = r_dmem_we;
      w_addr_nxt  = r_dmem_addr;
      w_wdata_nxt = r_dmem_wdata;
      w_halt_nxt  = r_halted;
      w_fault_nxt = r_fault;
      w_rf_we     = 1'b0;
      w_rf_idx    = w_rd;
      w_rf_data   = w_res;
      case (r_state)
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            case (w_op)
               4'h9, 4'hA, 4'hB, 4'hC: begin
                  if (w_guard) begin
                     w_state_nxt = S_HALT;
                     w_halt_nxt  = 1'b1;
                     w_fault_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_MEM;
                     w_req_nxt   = 1'b1;
                     w_we_nxt    = (w_op == 4'hA) || (w_op == 4'hB);
                     w_wdata_nxt = w_ry_val;
                     case (w_op)
                        4'hB:    w_addr_nxt = r_sp;
                        4'hC:    w_addr_nxt = r_sp + ONE_A;
                        default: w_addr_nxt = w_rx_val[AW-1:0];
                     endcase
                  end
               end
               4'hD: begin
                  w_pc_nxt    = w_taken ? w_tgt : r_pc + ONE_A;
                  w_state_nxt = S_FETCH;
               end
               4'hF: begin
                  w_state_nxt = S_HALT;
                  w_halt_nxt  = 1'b1;
               end
               default: begin
                  w_rf_we     = w_alu_wr;
                  w_pc_nxt    = r_pc + ONE_A;
                  w_state_nxt = S_FETCH;
                  if (w_flag_wr) begin
                     w_z_nxt = (w_res == '0);
                     w_n_nxt = w_res[DW-1];
                  end
               end
            endcase
         end
         S_MEM: begin
            if (dmem_ack) begin
               w_req_nxt   = 1'b0;
               w_pc_nxt    = r_pc + ONE_A;
               w_state_nxt = S_FETCH;
               w_rf_idx    = r_rd;
               w_rf_data   = dmem_rdata;
               w_rf_we     = (r_op == 4'h9) || (r_op == 4'hC);
               if (r_op == 4'hB) w_sp_nxt = r_sp - ONE_A;
               if (r_op == 4'hC) w_sp_nxt = r_sp + ONE_A;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc         <= '0;
         r_sp         <= SP_RST;
         r_z          <= 1'b0;
         r_n          <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_halted     <= 1'b0;
         r_fault      <= 1'b0;
         r_op         <= '0;
         r_rd         <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_sp         <= w_sp_nxt;
         r_z          <= w_z_nxt;
         r_n          <= w_n_nxt;
         r_dmem_req   <= w_req_nxt;
         r_dmem_we    <= w_we_nxt;
         r_dmem_addr  <= w_addr_nxt;
         r_dmem_wdata <= w_wdata_nxt;
         r_halted     <= w_halt_nxt;
         r_fault      <= w_fault_nxt;
         // Opcode and rd are kept for the ack cycle; the ROM output need not hold
         if (r_state == S_EXEC) begin
            r_op <= w_op;
            r_rd <= w_rd;
         end
         if (w_rf_we && (int'(w_rf_idx) < NREG)) r_regs[w_rf_idx] <= w_rf_data;
      end
   end

   assign imem_addr  = r_pc;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign halted     = r_halted;
   assign fault      = r_fault;

endmodule
